bilateral_weight_sched: RTL and testbench

//  Time-multiplexes one range-kernel (similarity) LUT across the 9 taps of a 3x3 window.
//  Per window: drives |tap-centre| to the shared LUT one tap per cycle, accumulates the

---
 rtl/bilateral_weight_sched.sv | 110 +++++++++++
 tb/tb_bilateral_weight_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bilateral_weight_sched.sv
// rtl/bilateral_weight_sched.sv - time-multiplexed range-kernel weight scheduler for a 3x3 bilateral filter
// Optional SPATIAL_WEIGHT_EN: applies a fixed 1-2-1 spatial kernel on top of the range weight.
module bilateral_weight_sched #(
   parameter int DATA_W   = 8,
   parameter int WEIGHT_W = 10,
   localparam int WSUM_W  = WEIGHT_W + 4,
   localparam int PSUM_W  = WEIGHT_W + DATA_W + 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [9*DATA_W-1:0] in_win,
   output logic [DATA_W-1:0]   lut_addr,
   input  logic [WEIGHT_W-1:0] lut_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WSUM_W-1:0]   out_wsum,
   output logic [PSUM_W-1:0]   out_psum
);

   localparam int W_W = WEIGHT_W + 2;
   localparam int P_W = W_W + DATA_W;

   typedef enum logic [1:0] {IDLE, LOOK, DONE} state_t;

   state_t              state;
   logic [9*DATA_W-1:0] win_q;
   logic [3:0]          tap;
   logic [WSUM_W-1:0]   acc_w;
   logic [PSUM_W-1:0]   acc_p;

   logic [DATA_W-1:0]   tap_pix;
   logic [DATA_W-1:0]   centre;
   logic [DATA_W-1:0]   diff;
   logic [W_W-1:0]      weight;
   logic [P_W-1:0]      prod;
   logic [WSUM_W-1:0]   wsum_nxt;
   logic [PSUM_W-1:0]   psum_nxt;

   assign tap_pix  = win_q[DATA_W*tap +: DATA_W];
   assign centre   = win_q[DATA_W*4 +: DATA_W];
   assign diff     = (tap_pix >= centre) ? (tap_pix - centre) : (centre - tap_pix);
   assign lut_addr = (state == LOOK) ? diff : '0;
   assign in_ready = (state == IDLE);

`ifdef SPATIAL_WEIGHT_EN
   always_comb begin
      weight = {2'b00, lut_data};
      case (tap)
         4'd4:                      weight = {lut_data, 2'b00};
         4'd1, 4'd3, 4'd5, 4'd7:    weight = {1'b0, lut_data, 1'b0};
         default:                   weight = {2'b00, lut_data};
      endcase
   end
`else
   assign weight = {2'b00, lut_data};
`endif

   assign prod     = {{DATA_W{1'b0}}, weight} * {{W_W{1'b0}}, tap_pix};
   assign wsum_nxt = acc_w + WSUM_W'(weight);
   assign psum_nxt = acc_p + PSUM_W'(prod);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         win_q     <= '0;
         tap       <= '0;
         acc_w     <= '0;
         acc_p     <= '0;
         out_valid <= 1'b0;
         out_wsum  <= '0;
         out_psum  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  win_q <= in_win;
                  tap   <= '0;
                  acc_w <= '0;
                  acc_p <= '0;
                  state <= LOOK;
               end
            end
            LOOK: begin
               acc_w <= wsum_nxt;
               acc_p <= psum_nxt;
               if (tap == 4'd8) begin
                  // Final tap folds straight into the output so DONE needs no extra cycle.
                  tap       <= '0;
                  out_wsum  <= wsum_nxt;
                  out_psum  <= psum_nxt;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  tap <= tap + 4'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bilateral_weight_sched.sv
// tb/tb_bilateral_weight_sched.sv - directed and random checks of bilateral_weight_sched
// Uses a combinational sigma_r LUT model: addr 0 -> 0x3FF, addr 0xFF -> 0x003.
module tb_bilateral_weight_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [71:0] in_win = '0;
   logic [7:0]  lut_addr;
   logic [9:0]  lut_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [13:0] out_wsum;
   logic [21:0] out_psum;

   int checks = 0;
   int errors = 0;

   bilateral_weight_sched #(.DATA_W(8), .WEIGHT_W(10)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_win(in_win),
      .lut_addr(lut_addr), .lut_data(lut_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_wsum(out_wsum), .out_psum(out_psum)
   );

   always #5 clk = ~clk;

   function automatic int lut_f(input int a);
      return ((255 - a) * (255 - a) * 1020) / 65025 + 3;
   endfunction

   always_comb lut_data = 10'(lut_f(int'(lut_addr)));

   function automatic void golden(input logic [71:0] w, output int ws, output int ps);
      int c, p, d, wt;
      c = int'(w[32 +: 8]);
      ws = 0;
      ps = 0;
      for (int k = 0; k < 9; k++) begin
         p  = int'(w[8*k +: 8]);
         d  = (p >= c) ? p - c : c - p;
         wt = lut_f(d);
`ifdef SPATIAL_WEIGHT_EN
         if (k == 4) wt = wt * 4;
         else if (k % 2 == 1) wt = wt * 2;
`endif
         ws += wt;
         ps += wt * p;
      end
   endfunction

   function automatic logic [71:0] uniform(input logic [7:0] v);
      return {9{v}};
   endfunction

   task automatic send(input logic [71:0] w);
      bit got;
      got = 0;
      @(negedge clk);
      in_win   = w;
      in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (in_ready) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      if (!got) begin
         errors++;
         $display("FAIL send_accept: in_ready=%0b required 1 within 40 cycles", in_ready);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic get_result(input bit rnd, output bit ok, output int ws, output int ps);
      ok = 0;
      ws = 0;
      ps = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid && out_ready) begin
            ok = 1;
            ws = int'(out_wsum);
            ps = int'(out_psum);
            @(posedge clk);
            #1 out_ready = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      checks++; if (lut_addr !== 8'd0) begin errors++; $display("FAIL reset_lut_addr: got %0d want 0", lut_addr); end
      checks++; if (out_wsum !== 14'd0) begin errors++; $display("FAIL reset_wsum: got %0d want 0", out_wsum); end
      checks++; if (out_psum !== 22'd0) begin errors++; $display("FAIL reset_psum: got %0d want 0", out_psum); end
   endtask

   task automatic test_uniform;
      int ew, ep;
`ifdef SPATIAL_WEIGHT_EN
      ew = 16368; ep = 1636800;
`else
      ew = 9207;  ep = 920700;
`endif
      out_ready = 1'b1;
      send(uniform(8'd100));
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== (i == 10)) begin
            errors++;
            $display("FAIL uniform_latency: cycle T+%0d out_valid=%0b want %0b", i, out_valid, (i == 10));
         end
      end
      checks++; if (out_wsum !== 14'(ew)) begin errors++; $display("FAIL uniform_wsum: got %0d want %0d", out_wsum, ew); end
      checks++; if (out_psum !== 22'(ep)) begin errors++; $display("FAIL uniform_psum: got %0d want %0d", out_psum, ep); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL uniform_in_ready_done: got %0b want 0", in_ready); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL uniform_valid_drop: got %0b want 0", out_valid); end
      checks++; if (out_wsum !== 14'(ew)) begin errors++; $display("FAIL uniform_wsum_hold: got %0d want %0d", out_wsum, ew); end
      out_ready = 1'b0;
   endtask

   task automatic test_centre_zero;
      logic [71:0] w;
      int ew, ep, ea;
`ifdef SPATIAL_WEIGHT_EN
      ew = 4128; ep = 9180;
`else
      ew = 1047; ep = 6120;
`endif
      w = uniform(8'd255);
      w[32 +: 8] = 8'd0;
      out_ready = 1'b1;
      send(w);
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         ea = (k == 4) ? 0 : 255;
         checks++;
         if (lut_addr !== 8'(ea)) begin
            errors++;
            $display("FAIL centre_lut_addr: tap %0d got 0x%0h want 0x%0h", k, lut_addr, ea);
         end
      end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL centre_valid: got %0b want 1", out_valid); end
      checks++; if (lut_addr !== 8'd0) begin errors++; $display("FAIL centre_addr_done: got %0d want 0", lut_addr); end
      checks++; if (out_wsum !== 14'(ew)) begin errors++; $display("FAIL centre_wsum: got %0d want %0d", out_wsum, ew); end
      checks++; if (out_psum !== 22'(ep)) begin errors++; $display("FAIL centre_psum: got %0d want %0d", out_psum, ep); end
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_stall;
      logic [71:0] w1, w2;
      int ew1, ep1, ew2, ep2, ws, ps;
      bit ok, seen;
      w1 = uniform(8'd200);
      w2 = uniform(8'd255);
      w2[32 +: 8] = 8'd0;
      golden(w1, ew1, ep1);
      golden(w2, ew2, ep2);
      out_ready = 1'b0;
      send(w1);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid) begin seen = 1; break; end
      end
      checks++; if (!seen) begin errors++; $display("FAIL stall_wait_valid: out_valid=%0b want 1", out_valid); end
      in_win   = w2;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: cycle %0d got %0b want 1", i, out_valid); end
         checks++; if (out_wsum !== 14'(ew1) || out_psum !== 22'(ep1)) begin
            errors++; $display("FAIL stall_sums: cycle %0d got %0d/%0d want %0d/%0d", i, out_wsum, out_psum, ew1, ep1);
         end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: cycle %0d got %0b want 0", i, in_ready); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL stall_release: out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
      end
      out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      get_result(1'b0, ok, ws, ps);
      checks++; if (!ok) begin errors++; $display("FAIL stall_w2_timeout: no result, want %0d/%0d", ew2, ep2); end
      checks++; if (ws !== ew2 || ps !== ep2) begin errors++; $display("FAIL stall_w2_sums: got %0d/%0d want %0d/%0d", ws, ps, ew2, ep2); end
   endtask

   task automatic test_reset_mid;
      logic [71:0] w;
      int ew, ep, ws, ps;
      bit ok;
      w = uniform(8'd255);
      w[32 +: 8] = 8'd0;
      out_ready = 1'b1;
      send(w);
      repeat (5) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || lut_addr !== 8'd0) begin
         errors++; $display("FAIL midrst_state: out_valid=%0b in_ready=%0b lut_addr=%0d want 0/1/0", out_valid, in_ready, lut_addr);
      end
      checks++; if (out_wsum !== 14'd0 || out_psum !== 22'd0) begin
         errors++; $display("FAIL midrst_sums: got %0d/%0d want 0/0", out_wsum, out_psum);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 2) rst = 1'b0;
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_output: cycle %0d got %0b want 0", i, out_valid); end
      end
      out_ready = 1'b0;
      w = uniform(8'd50);
      golden(w, ew, ep);
      send(w);
      get_result(1'b0, ok, ws, ps);
      checks++; if (!ok || ws !== ew || ps !== ep) begin
         errors++; $display("FAIL midrst_clean: ok=%0b got %0d/%0d want %0d/%0d", ok, ws, ps, ew, ep);
      end
   endtask

   task automatic test_back_to_back;
      logic [71:0] w;
      int ew, ep, ws, ps, received;
      bit ok;
      received = 0;
      for (int n = 0; n < 20; n++) begin
         for (int k = 0; k < 9; k++) w[8*k +: 8] = 8'($urandom_range(0, 255));
         golden(w, ew, ep);
         send(w);
         get_result(1'b1, ok, ws, ps);
         if (ok) received++;
         checks++; if (ws !== ew || ps !== ep) begin
            errors++; $display("FAIL b2b_sums: window %0d got %0d/%0d want %0d/%0d", n, ws, ps, ew, ep);
         end
      end
      checks++; if (received !== 20) begin errors++; $display("FAIL b2b_count: got %0d want 20", received); end
   endtask

   initial begin
      test_reset;
      test_uniform;
      test_centre_zero;
      test_stall;
      test_reset_mid;
      test_back_to_back;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
